// File: rtl/byte_serializer.sv
// rtl/byte_serializer.sv - emits the four splitter bytes of one word on a valid/ready byte stream
// Optional out_parity / word_count ports: define BYTE_SERIALIZER_PARITY_EN
module byte_serializer #(
   parameter int ORDER = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_o1,
   input  logic [7:0] in_o2,
   input  logic [7:0] in_o3,
   input  logic [7:0] in_o4,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_byte,
   output logic       out_last
`ifdef BYTE_SERIALIZER_PARITY_EN
   ,
   output logic       out_parity,
   output logic [7:0] word_count
`endif
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t      state, state_nxt;
   logic [1:0]  idx, idx_nxt;
   logic [31:0] word, word_nxt;
   logic [1:0]  sel;
   logic        accept;
   logic        xfer;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         idx   <= 2'd0;
         word  <= 32'h0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         word  <= word_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      word_nxt  = word;
      out_valid = (state == SEND);
      out_last  = (state == SEND) && (idx == 2'd3);
      // a new word may enter on the same edge the last byte leaves
      in_ready  = (state == IDLE) || (out_last && out_ready);
      accept    = in_valid && in_ready;
      xfer      = out_valid && out_ready;
      if (xfer) begin
         if (out_last) begin
            idx_nxt   = 2'd0;
            state_nxt = IDLE;
         end else begin
            idx_nxt   = idx + 2'd1;
         end
      end
      if (accept) begin
         word_nxt  = {in_o1, in_o2, in_o3, in_o4};
         idx_nxt   = 2'd0;
         state_nxt = SEND;
      end
   end

   // word holds O1 in the top byte; ORDER=1 walks it from the bottom
   always_comb begin
      sel = (ORDER == 0) ? idx : ~idx;
      case (sel)
         2'd0:    out_byte = word[31:24];
         2'd1:    out_byte = word[23:16];
         2'd2:    out_byte = word[15:8];
         default: out_byte = word[7:0];
      endcase
      if (!out_valid) out_byte = 8'h00;
   end

`ifdef BYTE_SERIALIZER_PARITY_EN
   logic [7:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       count <= 8'h00;
      else if (accept) count <= count + 8'h01;
   end

   assign word_count = count;
   assign out_parity = ^out_byte;
`endif

endmodule

// File: tb/tb_byte_serializer.sv
// tb/tb_byte_serializer.sv - self-checking bench for byte_serializer (ORDER 0 and 1 side by side)
// Optional parity checks follow BYTE_SERIALIZER_PARITY_EN
module tb_byte_serializer;

   typedef struct packed {
      logic [7:0] b;
      logic       last;
   } exp_t;

   typedef struct {
      logic [31:0] word;
      logic [31:0] seq0;
      logic [31:0] seq1;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       out_ready;
   logic [7:0] in_o1, in_o2, in_o3, in_o4;
   logic       in_ready0, out_valid0, out_last0;
   logic       in_ready1, out_valid1, out_last1;
   logic [7:0] out_byte0, out_byte1;
`ifdef BYTE_SERIALIZER_PARITY_EN
   logic       out_parity0, out_parity1;
   logic [7:0] word_count0, word_count1;
   logic [7:0] wc_model;
`endif

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   bit   done = 0;
   exp_t q0[$];
   exp_t q1[$];
   vec_t vecs[5];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   byte_serializer #(.ORDER(0)) dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
      .in_o1(in_o1), .in_o2(in_o2), .in_o3(in_o3), .in_o4(in_o4),
      .out_valid(out_valid0), .out_ready(out_ready), .out_byte(out_byte0), .out_last(out_last0)
`ifdef BYTE_SERIALIZER_PARITY_EN
      , .out_parity(out_parity0), .word_count(word_count0)
`endif
   );

   byte_serializer #(.ORDER(1)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
      .in_o1(in_o1), .in_o2(in_o2), .in_o3(in_o3), .in_o4(in_o4),
      .out_valid(out_valid1), .out_ready(out_ready), .out_byte(out_byte1), .out_last(out_last1)
`ifdef BYTE_SERIALIZER_PARITY_EN
      , .out_parity(out_parity1), .word_count(word_count1)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic send_word(input logic [31:0] w, input logic [31:0] s0, input logic [31:0] s1,
                            output int acc_cyc);
      bit   ok;
      exp_t e;
      ok = 0;
      in_valid = 1'b1;
      {in_o1, in_o2, in_o3, in_o4} = w;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         if (in_ready0) ok = 1;
         @(posedge clk);
         #1;
      end
      acc_cyc = cyc;
      in_valid = 1'b0;
      {in_o1, in_o2, in_o3, in_o4} = $urandom;
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL accept_timeout word=%h", w);
      end else begin
         for (int k = 0; k < 4; k++) begin
            e.b = s0[31-8*k -: 8];
            e.last = (k == 3);
            q0.push_back(e);
            e.b = s1[31-8*k -: 8];
            q1.push_back(e);
         end
`ifdef BYTE_SERIALIZER_PARITY_EN
         wc_model = wc_model + 8'h01;
         chk("word_count", word_count0, wc_model);
`endif
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 100 && q0.size() != 0; n++) begin
         @(posedge clk);
         #1;
      end
      chk("drain_left", q0.size(), 0);
      @(posedge clk);
      #1;
      chk("idle_valid", out_valid0, 1'b0);
      chk("idle_ready", in_ready0, 1'b1);
   endtask

   task automatic monitor();
      exp_t e;
      logic exp_ready;
      while (!done) begin
         @(negedge clk);
         if (!reset) begin
            if (q0.size() != 0) chk("no_bubble", out_valid0, 1'b1);
            exp_ready = !out_valid0;
            if (out_ready && q0.size() != 0) begin
               if (q0[0].last) exp_ready = 1'b1;
            end
            chk("in_ready", in_ready0, exp_ready);
`ifdef BYTE_SERIALIZER_PARITY_EN
            if (!out_valid0) chk("parity_idle", out_parity0, 1'b0);
`endif
            if (out_valid0 && out_ready) begin
               if (q0.size() == 0 || q1.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_byte actual=%h required=none", out_byte0);
               end else begin
                  e = q0.pop_front();
                  chk("byte_order0", out_byte0, e.b);
                  chk("last_order0", out_last0, e.last);
`ifdef BYTE_SERIALIZER_PARITY_EN
                  chk("parity", out_parity0, ^e.b);
`endif
                  e = q1.pop_front();
                  chk("byte_order1", out_byte1, e.b);
                  chk("last_order1", out_last1, e.last);
               end
            end
         end
      end
   endtask

   task automatic main_seq();
      int acc, prev;
      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      {in_o1, in_o2, in_o3, in_o4} = 32'hdeadbeef;
`ifdef BYTE_SERIALIZER_PARITY_EN
      wc_model = 8'h00;
`endif
      vecs[0] = '{32'hffff0010, 32'hffff0010, 32'h1000ffff};
      vecs[1] = '{32'hffff0000, 32'hffff0000, 32'h0000ffff};
      vecs[2] = '{32'h0ff0f00f, 32'h0ff0f00f, 32'h0ff0f00f};
      vecs[3] = '{32'h12345678, 32'h12345678, 32'h78563412};
      vecs[4] = '{32'ha55a0180, 32'ha55a0180, 32'h80015aa5};

      #12;
      chk("rst_valid", out_valid0, 1'b0);
      chk("rst_last", out_last0, 1'b0);
      chk("rst_byte", out_byte0, 8'h00);
      chk("rst_byte1", out_byte1, 8'h00);
      chk("rst_ready", in_ready0, 1'b1);
`ifdef BYTE_SERIALIZER_PARITY_EN
      chk("rst_parity", out_parity0, 1'b0);
      chk("rst_count", word_count0, 8'h00);
`endif
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      send_word(vecs[0].word, vecs[0].seq0, vecs[0].seq1, acc);
      chk("first_valid", out_valid0, 1'b1);
      chk("first_byte0", out_byte0, 8'hff);
      chk("first_byte1", out_byte1, 8'h10);
      drain();

      prev = 0;
      for (int i = 0; i < 5; i++) begin
         send_word(vecs[i].word, vecs[i].seq0, vecs[i].seq1, acc);
         if (i > 0) chk("b2b_spacing", acc - prev, 4);
         prev = acc;
      end
      drain();

      for (int i = 0; i < 2; i++) begin
         send_word(vecs[3*i].word, vecs[3*i].seq0, vecs[3*i].seq1, acc);
         @(posedge clk);
         #1;
         out_ready = 1'b0;
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_byte0", out_byte0, (i == 0) ? 8'hff : 8'h34);
            chk("bp_byte1", out_byte1, (i == 0) ? 8'h00 : 8'h56);
            chk("bp_ready", in_ready0, 1'b0);
            @(posedge clk);
            #1;
         end
         out_ready = 1'b1;
         drain();
      end

      send_word(vecs[4].word, vecs[4].seq0, vecs[4].seq1, acc);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      #2;
      reset = 1'b1;
      #1;
      chk("arst_valid", out_valid0, 1'b0);
      chk("arst_last", out_last0, 1'b0);
      chk("arst_byte", out_byte0, 8'h00);
      chk("arst_ready", in_ready0, 1'b1);
      q0.delete();
      q1.delete();
`ifdef BYTE_SERIALIZER_PARITY_EN
      wc_model = 8'h00;
`endif
      #3;
      reset = 1'b0;
      @(posedge clk);
      #1;
      send_word(32'h12345678, 32'h12345678, 32'h78563412, acc);
      chk("post_rst_byte0", out_byte0, 8'h12);
      chk("post_rst_byte1", out_byte1, 8'h78);
      drain();

`ifdef BYTE_SERIALIZER_PARITY_EN
      send_word(32'hffff0010, 32'hffff0010, 32'h1000ffff, acc);
      while (wc_model != 8'h00)
         send_word(32'hffff0010, 32'hffff0010, 32'h1000ffff, acc);
      chk("count_wrap", word_count0, 8'h00);
      drain();
`endif
      done = 1;
   endtask

   initial begin
      fork
         monitor();
         main_seq();
      join
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/byte_serializer.md
Name: byte_serializer

Overview:
- Sits directly downstream of the 32-bit splitter.
- Takes the four bytes O1..O4 the splitter produces from one word and emits them one byte per transfer on a valid/ready byte stream.
- Holds one word internally; back-to-back words stream with no bubble.
- Single clock domain; plain registers, no memories.

Parameters:
ORDER, 0, byte emission order: 0 = O1,O2,O3,O4 (O1 first); 1 = O4,O3,O2,O1 (O4 first)

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept a word this cycle
in_o1  input  8  splitter byte O1
in_o2  input  8  splitter byte O2
in_o3  input  8  splitter byte O3
in_o4  input  8  splitter byte O4
out_valid  output  1  out_byte valid
out_ready  input  1  downstream accepts the byte
out_byte  output  8  current byte
out_last  output  1  current byte is the 4th byte of its word

Behaviour:
- Reset:
  - clk is the only clock.
  - reset is asynchronous and active-high.
  - Asserting reset immediately forces state=IDLE, idx=0 and the held word register to 0.
  - Outputs under reset: out_valid=0, out_last=0, out_byte=8'h00, in_ready=1.
- Transfers:
  - Word accept occurs when in_valid && in_ready at a rising edge.
  - Byte transfer occurs when out_valid && out_ready at a rising edge.
- States:
  - IDLE: in_ready=1, out_valid=0. A word accept latches {in_o1..in_o4}, sets idx=0 and moves to SEND.
  - SEND: out_valid=1, out_byte = held byte selected by idx and ORDER.
- SEND transitions:
  - idx<3 and byte transfer: idx <= idx+1; stay in SEND.
  - idx==3 and byte transfer, with in_valid=1: new word latched, idx <= 0, stay in SEND (no bubble).
  - idx==3 and byte transfer, with in_valid=0: go to IDLE, idx <= 0.
  - out_ready=0: hold. out_byte, out_last and idx remain stable; no byte is skipped or repeated.
- in_ready = (state==IDLE) || (state==SEND && idx==3 && out_ready). It is combinational and depends on out_ready.
- in_valid while in_ready=0 is ignored; upstream must hold the word.
- out_last = (state==SEND && idx==3).
- Latency: first byte valid on the cycle after the word accept. A full word takes 4 byte transfers minimum.
- Throughput: 1 byte/cycle sustained when out_ready is held at 1 and in_valid is kept high.
- idx is 2 bits and never exceeds 3; no wrap beyond the word.
- Reset mid-word discards the remaining bytes. After release, the first accepted word starts at its first byte.
- The input bytes are sampled only on the accept edge. Later changes on in_o1..in_o4 do not affect the word being emitted.

Optional Feature:
- Macro: BYTE_SERIALIZER_PARITY_EN
- When defined:
  - Extra output port out_parity (1 bit) = even parity (XOR reduction) of out_byte, valid whenever out_valid=1, 0 when out_valid=0 or under reset.
  - An internal 8-bit word_count increments on each word accept, wraps 255->0 and resets to 0; it is readable via output port word_count (8 bits).
- When not defined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset, then word O1..O4 = ff,ff,00,10 (from 32'hffff0010), ORDER=0, out_ready=1 -> out_valid rises 1 cycle after accept; bytes ff,ff,00,10 on 4 consecutive cycles; out_last=1 only on 10; in_ready=1 on the 10 cycle; then IDLE.
- Same word with ORDER=1 -> sequence 10,00,ff,ff; out_last on the final ff.
- Back-to-back: words ff,ff,00,00 then 0f,f0,f0,0f with in_valid held high and out_ready=1 -> 8 bytes ff,ff,00,00,0f,f0,f0,0f on 8 consecutive cycles, no gap; second accept occurs on the edge of the first word's last byte.
- Backpressure: out_ready=0 for 3 cycles while byte 2 (ff) is shown -> out_byte stays ff, idx unchanged, in_ready=0; no byte lost or duplicated after out_ready returns to 1.
- Asynchronous reset pulsed mid-word after 2 bytes (not clock-aligned) -> out_valid drops immediately; next word 12,34,56,78 emits starting at 12.
- With BYTE_SERIALIZER_PARITY_EN: bytes ff,ff,00,10 -> out_parity 0,0,0,1; word_count=1 after accept. After 256 accepts, word_count=0.
